// File: rtl/thread_fifo_pkg.sv
// Shared types for the thread generator / ray core path.
// Defines SCREEN_COORD (coordinate width) unless the build already provides it.
`ifndef SCREEN_COORD
`define SCREEN_COORD 10
`endif

package thread_fifo_pkg;

   localparam int unsigned RAY_CORE_SIZE     = 4;
   localparam int unsigned THREAD_FIFO_DEPTH = 4;

   typedef struct packed {
      logic                       DataValid;
      logic [`SCREEN_COORD-1:0]   x;
      logic [`SCREEN_COORD-1:0]   y;
   } ThreadData;

   typedef struct packed {
      ThreadData thread;
      logic      frame_start;
   } RayCoreInput;

endpackage

// File: rtl/thread_fifo_if.sv
// Push/pop handshake between the thread generator, one thread_fifo and its ray core.
interface thread_fifo_if;
   import thread_fifo_pkg::*;

   ThreadData thread_in;
   logic      full;
   logic      almost_full;
   logic      pop;
   ThreadData thread_out;

   modport master (
      output thread_in,
      output pop,
      input  full,
      input  almost_full,
      input  thread_out
   );

   modport slave (
      input  thread_in,
      input  pop,
      output full,
      output almost_full,
      output thread_out
   );
endinterface

// File: rtl/thread_fifo_mem.sv
// DEPTH x ThreadData storage: synchronous write, asynchronous read for the show-ahead head.
module thread_fifo_mem
   import thread_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = THREAD_FIFO_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  ThreadData     wdata,
   input  logic [AW-1:0] raddr,
   output ThreadData     rdata
);

   ThreadData mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/thread_fifo.sv
// Per-ray-core show-ahead thread queue with registered full/almost_full and sticky overflow.
// Defining THREAD_FIFO_STATS_EN builds the high_water peak-occupancy tracker.
module thread_fifo
   import thread_fifo_pkg::*;
#(
   parameter int unsigned DEPTH             = THREAD_FIFO_DEPTH,
   parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         flush,
   thread_fifo_if.slave                 bus,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   high_water
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);

   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          full_q;
   logic          af_q;
   logic          ovf_q;
   logic          push_ok;
   logic          push_drop;
   logic          pop_ok;
   ThreadData     rdata;
   ThreadData     head;

   // full is the registered flag, so a same-cycle pop never rescues a push
   assign push_ok   = bus.thread_in.DataValid && !full_q && !flush;
   assign push_drop = bus.thread_in.DataValid &&  full_q && !flush;
   assign pop_ok    = bus.pop && (cnt_q != '0) && !flush;

   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else begin
         unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp     <= '0;
         rp     <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
         af_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (flush) begin
            wp    <= '0;
            rp    <= '0;
            ovf_q <= 1'b0;
         end else begin
            if (push_ok)   wp    <= wp + AW'(1);
            if (pop_ok)    rp    <= rp + AW'(1);
            if (push_drop) ovf_q <= 1'b1;
         end
         cnt_q  <= cnt_d;
         full_q <= (cnt_d == DEPTH_C);
         af_q   <= (cnt_d >= AF_C);
      end
   end

   thread_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wp),
      .wdata (bus.thread_in),
      .raddr (rp),
      .rdata (rdata)
   );

   // Gate the head with occupancy so stale or undefined memory never leaks out
   always_comb begin
      head           = rdata;
      head.DataValid = 1'b1;
      if (cnt_q == '0) head = '0;
   end

   assign bus.thread_out  = head;
   assign bus.full        = full_q;
   assign bus.almost_full = af_q;
   assign count           = cnt_q;
   assign overflow        = ovf_q;

`ifdef THREAD_FIFO_STATS_EN
   logic [CW-1:0] hw_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hw_q <= '0;
      end else if (cnt_d > hw_q) begin
         hw_q <= cnt_d;
      end
   end

   assign high_water = hw_q;
`else
   assign high_water = '0;
`endif

endmodule

// File: tb/tb_thread_fifo.sv
// Scoreboard bench for thread_fifo (DEPTH=4): stimulus queues expected post-edge state,
// a monitor pops and compares it after every rising edge.
module tb_thread_fifo;
   import thread_fifo_pkg::*;

   typedef struct {
      string name;
      bit    v;
      int    x;
      int    y;
      int    cnt;
      bit    full;
      bit    af;
      bit    ovf;
      int    hw;
   } exp_t;

   logic       clk;
   logic       resetn;
   logic       flush;
   logic [2:0] count;
   logic       overflow;
   logic [2:0] high_water;

   thread_fifo_if bus();

   thread_fifo #(
      .DEPTH             (4),
      .ALMOST_FULL_LEVEL (3)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (flush),
      .bus        (bus),
      .count      (count),
      .overflow   (overflow),
      .high_water (high_water)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int hwx(int v);
`ifdef THREAD_FIFO_STATS_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic compare(input exp_t e);
      exp_t a;
      a.v    = bus.thread_out.DataValid;
      a.x    = int'(bus.thread_out.x);
      a.y    = int'(bus.thread_out.y);
      a.cnt  = int'(count);
      a.full = bus.full;
      a.af   = bus.almost_full;
      a.ovf  = overflow;
      a.hw   = int'(high_water);
      n_checks++;
      if (a.v === e.v && a.x == e.x && a.y == e.y && a.cnt == e.cnt &&
          a.full === e.full && a.af === e.af && a.ovf === e.ovf && a.hw == e.hw) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got v=%0d x=%0d y=%0d cnt=%0d full=%0d af=%0d ovf=%0d hw=%0d, expected v=%0d x=%0d y=%0d cnt=%0d full=%0d af=%0d ovf=%0d hw=%0d",
                  e.name, a.v, a.x, a.y, a.cnt, a.full, a.af, a.ovf, a.hw,
                  e.v, e.x, e.y, e.cnt, e.full, e.af, e.ovf, e.hw);
      end
   endtask

   function automatic exp_t mk(string name, bit v, int x, int y, int cnt,
                               bit full, bit af, bit ovf, int hw);
      exp_t e;
      e.name = name; e.v = v; e.x = x; e.y = y; e.cnt = cnt;
      e.full = full; e.af = af; e.ovf = ovf; e.hw = hwx(hw);
      return e;
   endfunction

   // Drive one cycle of inputs and queue the state expected after the next edge
   task automatic step(input bit push, input int px, input int py, input bit pop,
                       input bit fl, input exp_t e);
      @(negedge clk);
      bus.thread_in.DataValid = push;
      bus.thread_in.x         = push ? `SCREEN_COORD'(px) : '0;
      bus.thread_in.y         = push ? `SCREEN_COORD'(py) : '0;
      bus.pop                 = pop;
      flush                   = fl;
      exp_q.push_back(e);
   endtask

   always begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) compare(exp_q.pop_front());
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected summary before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn       = 1'b0;
      flush        = 1'b0;
      bus.thread_in = '0;
      bus.pop      = 1'b0;
      repeat (2) @(posedge clk);
      #1 compare(mk("reset_state", 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk) resetn = 1'b1;

      // first push: visible one cycle later
      step(1, 3, 7, 0, 0, mk("push_x3y7",  1, 3, 7, 1, 0, 0, 0, 1));
      step(0, 0, 0, 1, 0, mk("pop_to_empty", 0, 0, 0, 0, 0, 0, 0, 1));

      // fill to full, then a dropped fifth push
      step(1, 0, 20, 0, 0, mk("fill_0", 1, 0, 20, 1, 0, 0, 0, 1));
      step(1, 1, 21, 0, 0, mk("fill_1", 1, 0, 20, 2, 0, 0, 0, 2));
      step(1, 2, 22, 0, 0, mk("fill_2_af", 1, 0, 20, 3, 0, 1, 0, 3));
      step(1, 3, 23, 0, 0, mk("fill_3_full", 1, 0, 20, 4, 1, 1, 0, 4));
      step(1, 4, 24, 0, 0, mk("push_full_drop", 1, 0, 20, 4, 1, 1, 1, 4));

      // drain; overflow is sticky; pop on empty is ignored
      step(0, 0, 0, 1, 0, mk("drain_1", 1, 1, 21, 3, 0, 1, 1, 4));
      step(0, 0, 0, 1, 0, mk("drain_2", 1, 2, 22, 2, 0, 0, 1, 4));
      step(0, 0, 0, 1, 0, mk("drain_3", 1, 3, 23, 1, 0, 0, 1, 4));
      step(0, 0, 0, 1, 0, mk("drain_empty", 0, 0, 0, 0, 0, 0, 1, 4));
      step(0, 0, 0, 1, 0, mk("pop_when_empty", 0, 0, 0, 0, 0, 0, 1, 4));

      // second fill exercises pointer wrap
      step(1, 10, 30, 0, 0, mk("wrap_fill_10", 1, 10, 30, 1, 0, 0, 1, 4));
      step(1, 11, 31, 0, 0, mk("wrap_fill_11", 1, 10, 30, 2, 0, 0, 1, 4));
      step(1, 12, 32, 0, 0, mk("wrap_fill_12", 1, 10, 30, 3, 0, 1, 1, 4));
      step(1, 13, 33, 0, 0, mk("wrap_fill_13", 1, 10, 30, 4, 1, 1, 1, 4));
      step(0, 0, 0, 1, 0, mk("wrap_pop_11", 1, 11, 31, 3, 0, 1, 1, 4));
      step(0, 0, 0, 1, 0, mk("wrap_pop_12", 1, 12, 32, 2, 0, 0, 1, 4));
      step(0, 0, 0, 1, 0, mk("wrap_pop_13", 1, 13, 33, 1, 0, 0, 1, 4));
      step(0, 0, 0, 1, 0, mk("wrap_pop_empty", 0, 0, 0, 0, 0, 0, 1, 4));

      // count 1 with simultaneous push and pop
      step(1, 5, 15, 0, 0, mk("single_x5", 1, 5, 15, 1, 0, 0, 1, 4));
      step(1, 6, 16, 1, 0, mk("pushpop_x6", 1, 6, 16, 1, 0, 0, 1, 4));
      step(0, 0, 0, 1, 0, mk("pop_x6", 0, 0, 0, 0, 0, 0, 1, 4));

      // push while full with pop: push still dropped
      step(1, 20, 40, 0, 0, mk("refill_20", 1, 20, 40, 1, 0, 0, 1, 4));
      step(1, 21, 41, 0, 0, mk("refill_21", 1, 20, 40, 2, 0, 0, 1, 4));
      step(1, 22, 42, 0, 0, mk("refill_22", 1, 20, 40, 3, 0, 1, 1, 4));
      step(1, 23, 43, 0, 0, mk("refill_23", 1, 20, 40, 4, 1, 1, 1, 4));
      step(1, 24, 44, 1, 0, mk("full_push_pop", 1, 21, 41, 3, 0, 1, 1, 4));

      // flush at count 3 with concurrent push; high_water retained
      step(1, 30, 50, 0, 1, mk("flush_push", 0, 0, 0, 0, 0, 0, 0, 4));
      step(1, 31, 51, 0, 0, mk("post_flush_31", 1, 31, 51, 1, 0, 0, 0, 4));
      step(1, 32, 52, 0, 0, mk("post_flush_32", 1, 31, 51, 2, 0, 0, 0, 4));

      // asynchronous reset mid-stream at count 2
      @(negedge clk);
      bus.thread_in = '0;
      @(posedge clk);
      #3 resetn = 1'b0;
      #1 compare(mk("async_reset", 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk) resetn = 1'b1;
      step(1, 9, 19, 0, 0, mk("after_reset_x9", 1, 9, 19, 1, 0, 0, 0, 1));

      @(negedge clk);
      bus.thread_in = '0;
      bus.pop       = 1'b0;
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
